// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types and helpers for the PWM ramp controller.
//   state_e   : controller FSM states (idle / sweep).
//   ch_w      : channel-index width, max(1, clog2(n_ch)).
//   ramp_step : one bounded ramp step of a compare value toward its target.
package pwm_ctrl_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StSweep
   } state_e;

   function automatic int unsigned ch_w(input int unsigned n_ch);
      int unsigned w;
      w = (n_ch <= 1) ? 1 : $clog2(n_ch);
      return w;
   endfunction

   // Operands are zero-extended to 32 bits, so the differences can never wrap
   // and the result lands exactly on tgt when it is within one step.
   function automatic logic [31:0] ramp_step(input logic [31:0] cur,
                                             input logic [31:0] tgt,
                                             input logic [31:0] step);
      logic [31:0] res;
      res = cur;
      if (tgt > cur) begin
         res = ((tgt - cur) > step) ? cur + step : tgt;
      end else if (tgt < cur) begin
         res = ((cur - tgt) > step) ? cur - step : tgt;
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_period_ctr.sv
// pwm_period_ctr: free-running Width-bit counter with a terminal-count tick.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   en   : count enable
//   tick : high while the count is all ones (forced low during reset)
module pwm_period_ctr #(
   parameter int unsigned Width = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_q + Width'(1);
      end
   end

   assign tick = (count_q == '1) && !rst;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: multi-channel duty-cycle ramp controller in front of N_CH pwm instances.
// Target writes arrive on a valid/ready port; each channel's compare value moves toward
// its target by at most STEP per period and all lanes are published together at the
// period boundary.
//   clk, rst    : clock, synchronous active-high reset
//   wr_valid    : target write request
//   wr_ready    : write can be accepted this cycle (idle state, not in reset)
//   wr_chan     : channel index
//   wr_duty     : target compare value
//   cmp_out     : packed compare values, lane i at [i*CTR_LEN +: CTR_LEN]
//   period_tick : last cycle of each period
//   err         : sticky, a write to an out-of-range channel was accepted
//   wdog_trip   : watchdog fired (constant 0 unless PWM_CTRL_WDOG_EN is defined)
// Optional feature macro: PWM_CTRL_WDOG_EN (write-inactivity watchdog).
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned CTR_LEN = 8,
   parameter int unsigned N_CH    = 4,
   parameter int unsigned STEP    = 4
`ifdef PWM_CTRL_WDOG_EN
   ,
   parameter int unsigned WDOG_PERIODS = 64
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ch_w(N_CH)-1:0]     wr_chan,
   input  logic [CTR_LEN-1:0]        wr_duty,
   output logic [N_CH*CTR_LEN-1:0]   cmp_out,
   output logic                      period_tick,
   output logic                      err,
   output logic                      wdog_trip
);

   localparam int unsigned ChW = ch_w(N_CH);

   state_e                    state_q, state_d;
   logic [ChW-1:0]            idx_q, idx_d;
   logic                      sweep_en;
   logic                      wr_fire;
   logic                      ch_ok;
   logic                      wdog_fire;
   logic                      err_q;
   logic [CTR_LEN-1:0]        tgt_q [N_CH];
   logic [CTR_LEN-1:0]        cur_q [N_CH];
   logic [N_CH*CTR_LEN-1:0]   cmp_q;

   pwm_period_ctr #(
      .Width (CTR_LEN)
   ) u_period_ctr (
      .clk  (clk),
      .rst  (rst),
      .en   (1'b1),
      .tick (period_tick)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wr_ready = 1'b0;
      sweep_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            wr_ready = !rst;
            if (period_tick) begin
               state_d = StSweep;
               idx_d   = '0;
            end
         end
         StSweep: begin
            sweep_en = 1'b1;
            if (idx_q == ChW'(N_CH - 1)) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + ChW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   assign wr_fire = wr_valid && wr_ready;
   assign ch_ok   = (32'(wr_chan) < N_CH);

   always_ff @(posedge clk) begin
      if (rst || wdog_fire) begin
         for (int i = 0; i < N_CH; i++) tgt_q[i] <= '0;
      end else if (wr_fire && ch_ok) begin
         for (int i = 0; i < N_CH; i++) begin
            if (wr_chan == ChW'(i)) tgt_q[i] <= wr_duty;
         end
      end
   end

   // One channel per sweep cycle; the sweep finishes well before the next tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) cur_q[i] <= '0;
      end else if (sweep_en) begin
         for (int i = 0; i < N_CH; i++) begin
            if (idx_q == ChW'(i)) begin
               cur_q[i] <= CTR_LEN'(ramp_step(32'(cur_q[i]), 32'(tgt_q[i]), 32'(STEP)));
            end
         end
      end
   end

   // Publishing only on the tick edge keeps every pwm compare stable within a period.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_q <= '0;
      end else if (period_tick) begin
         for (int i = 0; i < N_CH; i++) cmp_q[i*CTR_LEN +: CTR_LEN] <= cur_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (wr_fire && !ch_ok) begin
         err_q <= 1'b1;
      end
   end

   assign cmp_out = cmp_q;
   assign err     = err_q;

`ifdef PWM_CTRL_WDOG_EN
   localparam int unsigned WdW = $clog2(WDOG_PERIODS + 1);

   logic           wdog_q;
   logic [WdW-1:0] wdog_cnt_q;

   // An accepted write on the same tick wins over the trip.
   assign wdog_fire = period_tick && !wdog_q && !wr_fire &&
                      (wdog_cnt_q == WdW'(WDOG_PERIODS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt_q <= '0;
         wdog_q     <= 1'b0;
      end else begin
         if (wr_fire) begin
            wdog_cnt_q <= '0;
         end else if (period_tick && !wdog_q) begin
            wdog_cnt_q <= wdog_cnt_q + WdW'(1);
         end
         if (wdog_fire) begin
            wdog_q <= 1'b1;
         end else if (wr_fire && ch_ok) begin
            wdog_q <= 1'b0;
         end
      end
   end

   assign wdog_trip = wdog_q;
`else
   assign wdog_fire = 1'b0;
   assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: self-checking bench for pwm_ramp_ctrl (default build, watchdog off).
// N_CH = 3 so that channel index 3 is representable yet out of range.
module tb_pwm_ramp_ctrl;

   localparam int unsigned CTR_LEN = 8;
   localparam int unsigned N_CH    = 3;
   localparam int unsigned STEP    = 4;
   localparam int          MAXC    = 255;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    wr_valid = 1'b0;
   logic [1:0]              wr_chan = '0;
   logic [CTR_LEN-1:0]      wr_duty = '0;
   logic                    wr_ready;
   logic [N_CH*CTR_LEN-1:0] cmp_out;
   logic                    period_tick;
   logic                    err;
   logic                    wdog_trip;

   int total = 0;
   int bad   = 0;

   // Reference model
   int                      m_tgt [N_CH];
   int                      m_cur [N_CH];
   int                      m_cnt;
   int                      m_sweep;
   logic [N_CH*CTR_LEN-1:0] m_pub;
   logic                    m_err;
   logic                    m_err_pend;
   logic                    mon_en = 1'b0;
   logic [N_CH*CTR_LEN-1:0] exp_q [$];

   always #5 clk = ~clk;

   pwm_ramp_ctrl #(
      .CTR_LEN (CTR_LEN),
      .N_CH    (N_CH),
      .STEP    (STEP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_chan     (wr_chan),
      .wr_duty     (wr_duty),
      .cmp_out     (cmp_out),
      .period_tick (period_tick),
      .err         (err),
      .wdog_trip   (wdog_trip)
   );

   function automatic int ref_ramp(input int c, input int t);
      if (t - c > int'(STEP)) return c + int'(STEP);
      if (c - t > int'(STEP)) return c - int'(STEP);
      return t;
   endfunction

   function automatic logic [N_CH*CTR_LEN-1:0] pack_cur();
      logic [N_CH*CTR_LEN-1:0] v;
      int                      c;
      v = '0;
      for (int i = 0; i < N_CH; i++) begin
         c = m_cur[i];
         v[i*CTR_LEN +: CTR_LEN] = c[CTR_LEN-1:0];
      end
      return v;
   endfunction

   task automatic init_model();
      for (int i = 0; i < N_CH; i++) begin
         m_tgt[i] = 0;
         m_cur[i] = 0;
      end
      m_cnt      = 0;
      m_sweep    = 0;
      m_pub      = '0;
      m_err      = 1'b0;
      m_err_pend = 1'b0;
      exp_q.delete();
   endtask

   // Cycle monitor: checks tick timing, ready, err and the published lanes every cycle.
   always @(negedge clk) begin
      #2;
      if (mon_en && !rst) begin
         total++;
         if (period_tick !== (m_cnt == MAXC)) begin
            bad++;
            $display("FAIL period_tick cnt=%0d got=%b want=%b", m_cnt, period_tick, m_cnt == MAXC);
         end
         total++;
         if (wr_ready !== (m_sweep == 0)) begin
            bad++;
            $display("FAIL wr_ready cnt=%0d got=%b want=%b", m_cnt, wr_ready, m_sweep == 0);
         end
         total++;
         if (err !== m_err) begin
            bad++;
            $display("FAIL err got=%b want=%b", err, m_err);
         end
         total++;
         if (wdog_trip !== 1'b0) begin
            bad++;
            $display("FAIL wdog_trip got=%b want=0", wdog_trip);
         end
         if (exp_q.size() > 0) m_pub = exp_q.pop_front();
         total++;
         if (cmp_out !== m_pub) begin
            bad++;
            $display("FAIL cmp_out cnt=%0d got=%h want=%h", m_cnt, cmp_out, m_pub);
         end
         if (m_err_pend) begin
            m_err      = 1'b1;
            m_err_pend = 1'b0;
         end
         if (m_cnt == MAXC) begin
            exp_q.push_back(pack_cur());
            for (int i = 0; i < N_CH; i++) m_cur[i] = ref_ramp(m_cur[i], m_tgt[i]);
            m_sweep = N_CH;
         end else if (m_sweep > 0) begin
            m_sweep--;
         end
         m_cnt = (m_cnt + 1) % (MAXC + 1);
      end
   end

   // Called at a negedge; holds wr_valid until a transfer, returns at the next negedge.
   task automatic do_write(input int chan, input int duty, output int waited);
      wr_chan  = chan[1:0];
      wr_duty  = duty[CTR_LEN-1:0];
      wr_valid = 1'b1;
      waited   = 0;
      while (!wr_ready && waited < 600) begin
         @(negedge clk);
         waited++;
      end
      if (!wr_ready) begin
         total++;
         bad++;
         $display("FAIL write_timeout chan=%0d waited=%0d want<600", chan, waited);
      end else if (chan < int'(N_CH)) begin
         m_tgt[chan] = duty;
      end else begin
         m_err_pend = 1'b1;
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (period_tick !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (period_tick !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL tick_timeout waited=%0d want<300", n);
      end
   endtask

   // Returns at the first cycle after a tick, when the new lanes are visible.
   task automatic wait_pub();
      int n;
      wait_tick(n);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      wr_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (wr_ready !== 1'b0 || cmp_out !== '0 || period_tick !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_vals got ready=%b cmp=%h tick=%b err=%b want 0 0 0 0",
                  wr_ready, cmp_out, period_tick, err);
      end
      rst = 1'b0;
      init_model();
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if (wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_reset got=%b want=1", wr_ready);
      end
   endtask

   task automatic test_ramp_up();
      int w;
      int e;
      do_write(0, 200, w);
      for (int k = 0; k <= 52; k++) begin
         wait_pub();
         e = (4 * k > 200) ? 200 : 4 * k;
         total++;
         if (cmp_out[0 +: CTR_LEN] !== e[CTR_LEN-1:0]) begin
            bad++;
            $display("FAIL ramp_up k=%0d got=%0d want=%0d", k, cmp_out[0 +: CTR_LEN], e);
         end
      end
   endtask

   task automatic test_no_overshoot();
      int w;
      do_write(1, 10, w);
      repeat (4) wait_pub();
      total++;
      if (cmp_out[8 +: 8] !== 8'd10) begin
         bad++;
         $display("FAIL settle_10 got=%0d want=10", cmp_out[8 +: 8]);
      end
      do_write(1, 7, w);
      wait_pub();
      wait_pub();
      total++;
      if (cmp_out[8 +: 8] !== 8'd7) begin
         bad++;
         $display("FAIL down_to_7 got=%0d want=7", cmp_out[8 +: 8]);
      end
      do_write(0, 253, w);
      repeat (15) wait_pub();
      total++;
      if (cmp_out[0 +: 8] !== 8'd253) begin
         bad++;
         $display("FAIL settle_253 got=%0d want=253", cmp_out[0 +: 8]);
      end
      do_write(0, 255, w);
      wait_pub();
      wait_pub();
      total++;
      if (cmp_out[0 +: 8] !== 8'd255) begin
         bad++;
         $display("FAIL top_255 got=%0d want=255", cmp_out[0 +: 8]);
      end
      wait_pub();
      total++;
      if (cmp_out[0 +: 8] !== 8'd255) begin
         bad++;
         $display("FAIL hold_255 got=%0d want=255", cmp_out[0 +: 8]);
      end
   endtask

   task automatic test_hold_through_sweep();
      int n;
      int w;
      wait_tick(n);
      @(negedge clk);
      do_write(2, 150, w);
      total++;
      if (w !== int'(N_CH)) begin
         bad++;
         $display("FAIL ready_low_cycles got=%0d want=%0d", w, N_CH);
      end
      wait_pub();
      wait_pub();
      total++;
      if (cmp_out[16 +: 8] !== 8'd4) begin
         bad++;
         $display("FAIL held_write_lane2 got=%0d want=4", cmp_out[16 +: 8]);
      end
   endtask

   task automatic test_bad_chan();
      int w;
      do_write(3, 99, w);
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL err_set got=%b want=1", err);
      end
      repeat (2) wait_pub();
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky got=%b want=1", err);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      wait_tick(n);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (cmp_out !== '0 || wr_ready !== 1'b0 || err !== 1'b0 || period_tick !== 1'b0) begin
         bad++;
         $display("FAIL mid_sweep_reset got cmp=%h ready=%b err=%b tick=%b want 0 0 0 0",
                  cmp_out, wr_ready, err, period_tick);
      end
      rst = 1'b0;
      init_model();
      wait_tick(n);
      total++;
      if (n !== 255) begin
         bad++;
         $display("FAIL counter_restart got=%0d want=255", n);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      do_write(1, 40, w);
      do_write(1, 20, w);
      repeat (8) wait_pub();
      total++;
      if (cmp_out[8 +: 8] !== 8'd20) begin
         bad++;
         $display("FAIL last_writer_wins got=%0d want=20", cmp_out[8 +: 8]);
      end
   endtask

   initial begin
      init_model();
      test_reset();
      test_ramp_up();
      test_no_overshoot();
      test_hold_through_sweep();
      test_bad_chan();
      test_reset_mid_sweep();
      test_back_to_back();
      @(negedge clk);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
